arb_rr_bin: RTL and testbench
=============================

// Module: arb_rr_bin
// PURPOSE
//  Round-robin arbiter with binary-encoded grant; the stage directly upstream of mux_bin.
//  Picks one of WIDTH requesters and drives the registered index bin into mux_bin.bin.
//  Holds the grant until the downstream transfer is acknowledged, with optional multi-beat lock.
//  Rotating priority prevents starvation; back-to-back grants have no bubble cycles.
// PARAMETERS
//  WIDTH          16  number of requesters (>=2, need not be a power of 2)
//  SPLIT           4  fan-in per level of the internal priority-encoder tree; must not change behaviour
//  IMPLEMENTATION  0  encoder-tree architecture select; every value is cycle-identical at the ports
//  (local) WIDTH_LOG = $clog2(WIDTH)
// PORTS
//  clk  input   1          clock, rising edge
//  rst_n  input   1          reset, asynchronous assert, active-low
//  req  input   WIDTH      request vector, bit i = requester i
//  lck  input   WIDTH      lck[i]=1: requester i keeps the grant after the current ack (multi-beat)
//  ack  input   1          downstream accepted the beat selected by bin this cycle
//  vld  output  1          a grant is active; bin/gnt are meaningful
//  bin  output  WIDTH_LOG  granted index (registered), connects to mux_bin.bin
//  gnt  output  WIDTH      one-hot grant, equals vld ? (1<<bin) : 0
// BEHAVIOUR
//  Reset (rst_n=0, async): vld=0, bin=0, gnt=0, ptr=0, state=IDLE. Index 0 has first priority.
//  ptr: internal WIDTH_LOG-bit priority pointer. Search order is ptr, ptr+1, ... WIDTH-1, 0, ... ptr-1.
//  pick(v): first set bit of v in search order. All outputs are flops; no comb path from req/ack to bin.
//  States:
//   IDLE : vld=0. If |req, load bin=pick(req) and vld=1, then go to GRANT. Otherwise stay.
//   GRANT: hold bin and vld while ack=0 and req[bin]=1.
//    ack & lck[bin] & req[bin]: keep bin, go to LOCK, ptr unchanged.
//    ack & no lock: ptr=(bin+1) mod WIDTH. Re-arbitrate this cycle with the new ptr over req.
//      If any request is pending: load the new bin next cycle, vld stays 1 (no bubble).
//      If none is pending: go to IDLE, vld=0.
//    ~req[bin] (withdrawal, ack=0): treated as an un-locked ack. ptr advances and re-arbitration runs.
//   LOCK : same as GRANT. Grant persists while lck[bin]=1 across acks. The first ack with lck[bin]=0 releases it.
//  Latency: req to vld/bin is 1 cycle. Ack to next grant is 1 cycle.
//  Wrap: ptr and the search wrap WIDTH-1 -> 0. For non-pow2 WIDTH, bin < WIDTH always holds.
//  Simultaneous events:
//   - Requests arriving in the ack cycle take part in the re-arbitration.
//   - Re-arbitration excludes nothing: the just-served requester is lowest priority via ptr only.
//  lck is sampled only on ack cycles and only for index bin. lck bits of other indices are ignored.
//  Reset mid-grant: outputs return to reset values immediately. Any in-flight beat is lost (system contract).
//  Invariant: vld=1 implies req[bin] was 1 on the previous edge. gnt is onehot0.
// TESTING (WIDTH=16, SPLIT=4, all IMPLEMENTATION values, checked against a behavioural model)
//  1. reset, then req=16'h0020 -> next cycle vld=1 bin=5 gnt=16'h0020. ack=1 with req=0 -> next cycle vld=0, ptr=6.
//  2. reset, req=16'hFFFF, ack=1 every cycle -> bin=0,1,2..15,0,1 on consecutive cycles, vld never drops.
//  3. ptr=13, req={bit12,bit3} -> bin=3 first. After ack -> bin=12 (wrap through 15->0).
//  4. req[7]&req[2], lck[7]=1 for 3 acks -> bin=7 on all 3 beats. Ack with lck[7]=0 -> next bin=2.
//  5. Grant bin=9 active, req[9] dropped with ack=0 -> next cycle moves to the next pending index, or vld=0; ptr=10.
//  6. rst_n pulsed low mid-LOCK (asynchronously, between edges) -> vld=0/bin=0/gnt=0 at once. First grant after release starts the search at 0.

Source files
------------

// File: rtl/arb_rr_bin.sv
// Round-robin arbiter with a registered binary grant index, hold-until-ack and multi-beat lock.
// Drives mux_bin.bin; every output comes straight from a flop.
module arb_rr_bin #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned SPLIT          = 4,
  parameter int unsigned IMPLEMENTATION = 0,
  localparam int unsigned WIDTH_LOG     = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     req,
  input  logic [WIDTH-1:0]     lck,
  input  logic                 ack,
  output logic                 vld,
  output logic [WIDTH_LOG-1:0] bin,
  output logic [WIDTH-1:0]     gnt
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StLock  = 2'd2;

  // Encoder tree geometry; a fan-in below 2 would never converge, so it is clamped.
  localparam int unsigned SPLIT_E = (SPLIT < 2) ? 2 : SPLIT;

  function automatic int unsigned tree_levels(input int unsigned w, input int unsigned s);
    int unsigned n;
    int unsigned l;
    n = 1;
    l = 0;
    while (n < w) begin
      n = n * s;
      l = l + 1;
    end
    if (l == 0) l = 1;
    return l;
  endfunction

  localparam int unsigned LEVELS = tree_levels(WIDTH, SPLIT_E);
  localparam int unsigned NPAD   = SPLIT_E ** LEVELS;
  localparam int unsigned IDX_W  = $clog2(NPAD);

  // All encoders return {found, index of lowest set bit}.
  function automatic logic [WIDTH_LOG:0] enc_tree(input logic [WIDTH-1:0] v);
    logic [NPAD-1:0]  ok;
    logic [IDX_W-1:0] idx [NPAD];
    logic [IDX_W-1:0] t;
    logic [IDX_W-1:0] top;
    logic             f;
    int unsigned      span;
    ok             = '0;
    ok[WIDTH-1:0]  = v;
    for (int i = 0; i < NPAD; i++) idx[i] = IDX_W'(i);
    span = NPAD;
    for (int l = 0; l < LEVELS; l++) begin
      span = span / SPLIT_E;
      for (int n = 0; n < NPAD; n++) begin
        if (n < span) begin
          f = 1'b0;
          t = '0;
          for (int s = SPLIT_E - 1; s >= 0; s--) begin
            if (ok[n * SPLIT_E + s]) begin
              f = 1'b1;
              t = idx[n * SPLIT_E + s];
            end
          end
          // Node n is written only after its children (all >= n) have been read.
          ok[n]  = f;
          idx[n] = t;
        end
      end
    end
    top = idx[0];
    return {ok[0], top[WIDTH_LOG-1:0]};
  endfunction

  function automatic logic [WIDTH_LOG:0] enc_linear(input logic [WIDTH-1:0] v);
    logic                 f;
    logic [WIDTH_LOG-1:0] idx;
    f   = 1'b0;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        f   = 1'b1;
        idx = WIDTH_LOG'(i);
      end
    end
    return {f, idx};
  endfunction

  function automatic logic [WIDTH_LOG:0] enc_isolate(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0]     oh;
    logic [WIDTH_LOG-1:0] idx;
    oh  = v & (~v + 1'b1);
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (oh[i]) idx = idx | WIDTH_LOG'(i);
    end
    return {|v, idx};
  endfunction

  function automatic logic [WIDTH_LOG:0] enc(input logic [WIDTH-1:0] v);
    if (IMPLEMENTATION == 1) return enc_linear(v);
    else if (IMPLEMENTATION == 2) return enc_isolate(v);
    else return enc_tree(v);
  endfunction

  logic [1:0]           r_state;
  logic [1:0]           w_state_d;
  logic [WIDTH_LOG-1:0] r_ptr;
  logic [WIDTH_LOG-1:0] w_ptr_d;
  logic                 r_vld;
  logic                 w_vld_d;
  logic [WIDTH_LOG-1:0] r_bin;
  logic [WIDTH_LOG-1:0] w_bin_d;
  logic [WIDTH-1:0]     r_gnt;
  logic [WIDTH-1:0]     w_gnt_d;

  logic [WIDTH_LOG-1:0] w_rel_ptr;
  logic [WIDTH_LOG-1:0] w_srch_ptr;
  logic [WIDTH-1:0]     w_hi_mask;
  logic [WIDTH_LOG:0]   w_enc_hi;
  logic [WIDTH_LOG:0]   w_enc_all;
  logic                 w_pick_any;
  logic [WIDTH_LOG-1:0] w_pick_idx;
  logic                 w_cur_req;
  logic                 w_cur_lck;

  assign w_rel_ptr  = (r_bin == WIDTH_LOG'(WIDTH - 1)) ? '0 : r_bin + 1'b1;
  // Idle arbitration searches from the stored pointer; a release searches past the served index.
  assign w_srch_ptr = (r_state == StIdle) ? r_ptr : w_rel_ptr;
  assign w_cur_req  = req[r_bin];
  assign w_cur_lck  = lck[r_bin];

  always_comb begin
    w_hi_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_hi_mask[i] = (WIDTH_LOG'(i) >= w_srch_ptr);
    end
  end

  // Rotating pick: lowest request at or above the pointer, else lowest overall (wrap).
  assign w_enc_hi   = enc(req & w_hi_mask);
  assign w_enc_all  = enc(req);
  assign w_pick_any = w_enc_all[WIDTH_LOG];
  assign w_pick_idx = w_enc_hi[WIDTH_LOG] ? w_enc_hi[WIDTH_LOG-1:0] : w_enc_all[WIDTH_LOG-1:0];

  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_vld_d   = r_vld;
    w_bin_d   = r_bin;
    case (r_state)
      StIdle: begin
        if (w_pick_any) begin
          w_bin_d   = w_pick_idx;
          w_vld_d   = 1'b1;
          w_state_d = StGrant;
        end
      end
      StGrant, StLock: begin
        if (ack && w_cur_lck && w_cur_req) begin
          w_state_d = StLock;
        end else if (ack || !w_cur_req) begin
          w_ptr_d = w_rel_ptr;
          if (w_pick_any) begin
            w_bin_d   = w_pick_idx;
            w_state_d = StGrant;
          end else begin
            w_vld_d   = 1'b0;
            w_state_d = StIdle;
          end
        end
      end
      default: begin
        w_vld_d   = 1'b0;
        w_state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    w_gnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_gnt_d[i] = w_vld_d && (w_bin_d == WIDTH_LOG'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_vld   <= 1'b0;
      r_bin   <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_vld   <= w_vld_d;
      r_bin   <= w_bin_d;
      r_gnt   <= w_gnt_d;
    end
  end

  assign vld = r_vld;
  assign bin = r_bin;
  assign gnt = r_gnt;

endmodule

// File: tb/tb_arb_rr_bin.sv
// Bench for arb_rr_bin: all three encoder architectures run side by side against a
// cycle-level round-robin model, plus directed literal expectations.
module tb_arb_rr_bin;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] req = '0;
  logic [15:0] lck = '0;
  logic        ack = 1'b0;

  logic        vld0, vld1, vld2;
  logic [3:0]  bin0, bin1, bin2;
  logic [15:0] gnt0, gnt1, gnt2;

  int checks = 0;
  int errors = 0;

  int m_ptr = 0;
  int m_bin = 0;
  bit m_vld = 1'b0;

  always #5 clk = ~clk;

  arb_rr_bin #(.WIDTH(16), .SPLIT(4), .IMPLEMENTATION(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .lck(lck), .ack(ack),
    .vld(vld0), .bin(bin0), .gnt(gnt0)
  );
  arb_rr_bin #(.WIDTH(16), .SPLIT(4), .IMPLEMENTATION(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .lck(lck), .ack(ack),
    .vld(vld1), .bin(bin1), .gnt(gnt1)
  );
  arb_rr_bin #(.WIDTH(16), .SPLIT(4), .IMPLEMENTATION(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .lck(lck), .ack(ack),
    .vld(vld2), .bin(bin2), .gnt(gnt2)
  );

  function automatic int pick(input logic [15:0] v, input int p);
    for (int k = 0; k < 16; k++) begin
      int i;
      i = (p + k) % 16;
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Model: a grant is a (vld, bin) pair; served requester hands priority to bin+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld = 1'b0;
      m_bin = 0;
      m_ptr = 0;
    end else if (!m_vld) begin
      if (req != 16'h0) begin
        m_bin = pick(req, m_ptr);
        m_vld = 1'b1;
      end
    end else if (ack && lck[m_bin] && req[m_bin]) begin
      m_bin = m_bin;
    end else if (ack || !req[m_bin]) begin
      m_ptr = (m_bin + 1) % 16;
      if (req != 16'h0) m_bin = pick(req, m_ptr);
      else m_vld = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string n, input logic v, input logic [3:0] b,
                         input logic [15:0] g);
    chk({n, " vld"}, 32'(v), 32'(m_vld));
    chk({n, " gnt"}, 32'(g), m_vld ? (32'h1 << m_bin) : 32'h0);
    if (m_vld) chk({n, " bin"}, 32'(b), 32'(m_bin));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cmp_dut("impl0", vld0, bin0, gnt0);
      cmp_dut("impl1", vld1, bin1, gnt1);
      cmp_dut("impl2", vld2, bin2, gnt2);
    end
  end

  task automatic exp_out(input string n, input bit v, input int b, input logic [15:0] g);
    chk({n, " vld"}, 32'(vld0), 32'(v));
    chk({n, " gnt"}, 32'(gnt0), 32'(g));
    if (v) chk({n, " bin"}, 32'(bin0), 32'(b));
  endtask

  task automatic drive(input logic [15:0] r, input logic [15:0] l, input logic a);
    req = r;
    lck = l;
    ack = a;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(16'h0, 16'h0, 1'b0);
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    // 1: single request, release to idle, pointer lands past the served index
    drive(16'h0, 16'h0, 1'b0);
    #1 rst_n = 1'b0;
    tick();
    chk("reset vld", 32'(vld0), 32'h0);
    chk("reset bin", 32'(bin0), 32'h0);
    chk("reset gnt", 32'(gnt0), 32'h0);
    rst_n = 1'b1;
    tick();
    drive(16'h0020, 16'h0, 1'b0); tick(); exp_out("t1 grant5", 1, 5, 16'h0020);
    drive(16'h0000, 16'h0, 1'b1); tick(); exp_out("t1 idle", 0, 0, 16'h0);
    chk("t1 model ptr", 32'(m_ptr), 32'd6);
    drive(16'h0041, 16'h0, 1'b0); tick(); exp_out("t1 ptr6 pick", 1, 6, 16'h0040);
    drive(16'h0000, 16'h0, 1'b1); tick(); exp_out("t1 idle2", 0, 0, 16'h0);

    // 2: all requesting, ack every cycle: strict rotation without bubbles
    do_reset();
    drive(16'hFFFF, 16'h0, 1'b1);
    for (int i = 0; i < 18; i++) begin
      tick();
      exp_out("t2 rotate", 1, i % 16, 16'(32'h1 << (i % 16)));
    end
    drive(16'h0, 16'h0, 1'b1); tick(); exp_out("t2 idle", 0, 0, 16'h0);

    // 3: pointer 13, wrap through 15 -> 0
    do_reset();
    drive(16'h1000, 16'h0, 1'b0); tick(); exp_out("t3 grant12", 1, 12, 16'h1000);
    drive(16'h0000, 16'h0, 1'b1); tick(); exp_out("t3 idle", 0, 0, 16'h0);
    chk("t3 model ptr", 32'(m_ptr), 32'd13);
    drive(16'h1008, 16'h0, 1'b0); tick(); exp_out("t3 wrap3", 1, 3, 16'h0008);
    drive(16'h1008, 16'h0, 1'b1); tick(); exp_out("t3 next12", 1, 12, 16'h1000);
    drive(16'h0000, 16'h0, 1'b1); tick(); exp_out("t3 idle2", 0, 0, 16'h0);

    // 4: multi-beat lock on 7, then release to 2; lck of other indices ignored
    do_reset();
    drive(16'h0004, 16'h0, 1'b0); tick(); exp_out("t4 grant2", 1, 2, 16'h0004);
    drive(16'h0000, 16'h0, 1'b1); tick(); exp_out("t4 idle", 0, 0, 16'h0);
    drive(16'h0084, 16'h0080, 1'b0); tick(); exp_out("t4 grant7", 1, 7, 16'h0080);
    for (int k = 0; k < 3; k++) begin
      drive(16'h0084, 16'h0080, 1'b1); tick(); exp_out("t4 locked7", 1, 7, 16'h0080);
    end
    drive(16'h0084, 16'h0000, 1'b1); tick(); exp_out("t4 unlock2", 1, 2, 16'h0004);
    drive(16'h0084, 16'h0080, 1'b1); tick(); exp_out("t4 foreign lck", 1, 7, 16'h0080);
    drive(16'h0000, 16'h0, 1'b1); tick(); exp_out("t4 idle2", 0, 0, 16'h0);

    // 5: withdrawal of the granted request acts as an unlocked ack
    do_reset();
    drive(16'h0200, 16'h0, 1'b0); tick(); exp_out("t5 grant9", 1, 9, 16'h0200);
    drive(16'h0011, 16'h0, 1'b0); tick(); exp_out("t5 withdraw", 1, 0, 16'h0001);
    chk("t5 model ptr", 32'(m_ptr), 32'd10);
    drive(16'h0000, 16'h0, 1'b0); tick(); exp_out("t5 withdraw idle", 0, 0, 16'h0);
    chk("t5 model ptr2", 32'(m_ptr), 32'd1);

    // 6: asynchronous reset in the middle of a lock
    do_reset();
    drive(16'h0004, 16'h0, 1'b0); tick(); exp_out("t6 grant2", 1, 2, 16'h0004);
    drive(16'h0000, 16'h0, 1'b1); tick();
    drive(16'h0010, 16'h0010, 1'b0); tick(); exp_out("t6 grant4", 1, 4, 16'h0010);
    drive(16'h0010, 16'h0010, 1'b1); tick(); exp_out("t6 lock4", 1, 4, 16'h0010);
    drive(16'h0010, 16'h0010, 1'b1); tick(); exp_out("t6 lock4b", 1, 4, 16'h0010);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async vld", 32'(vld0), 32'h0);
    chk("t6 async bin", 32'(bin0), 32'h0);
    chk("t6 async gnt", 32'(gnt0), 32'h0);
    #3 rst_n = 1'b1;
    drive(16'h8011, 16'h0, 1'b0); tick(); exp_out("t6 restart0", 1, 0, 16'h0001);
    drive(16'h0000, 16'h0, 1'b1); tick(); exp_out("t6 idle", 0, 0, 16'h0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
